// File: rtl/uart_cmd_pkg.sv
// Shared types and defaults for the knight-side UART command link.
// Consumers: uart_cmd_wrapper (top) and the testbench.
package uart_cmd_pkg;

   // Byte-assembly FSM: waiting for the high byte, or waiting for the low byte.
   typedef enum logic [0:0] {
      HIGH = 1'b0,
      LOW  = 1'b1
   } state_t;

   // Clocks allowed between high byte and low byte when the timeout is built in.
   localparam int DEFAULT_TIMEOUT_CYCLES = 100000;

   // Clocks per serial bit (19200 baud from a 50 MHz clock).
   localparam int DEFAULT_BAUD_DIV = 2604;

   // Commands are always {high_byte, low_byte}; keep that ordering in one place.
   function automatic logic [15:0] pack_cmd(input logic [7:0] hi, input logic [7:0] lo);
      return {hi, lo};
   endfunction

endpackage

// File: rtl/uart.sv
// UART transceiver, 8N1, LSB first.
// TX: trmt loads tx_data and starts a frame; it is ignored while a frame is
//     in flight.  tx_done rises after the stop bit and holds until the next
//     accepted trmt.  TX idles high.
// RX: RX is double-flopped, bits are sampled mid-bit.  rx_rdy is level-held
//     from the stop-bit sample until clr_rx_rdy.  A start bit that is no longer
//     low at its mid-point is treated as a glitch and dropped.
module uart #(
   parameter int BAUD_DIV = 2604
)(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       RX,
   output logic       TX,
   input  logic [7:0] tx_data,
   input  logic       trmt,
   output logic       tx_done,
   output logic [7:0] rx_data,
   output logic       rx_rdy,
   input  logic       clr_rx_rdy
);

   localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
   localparam logic [15:0] BAUD_HALF = 16'(BAUD_DIV / 2);

   logic [9:0]  tx_shift_r;
   logic [15:0] tx_baud_r;
   logic [3:0]  tx_bit_r;
   logic        tx_busy_r;
   logic        tx_done_r;

   logic        rx_meta_r;
   logic        rx_sync_r;
   logic        rx_busy_r;
   logic [15:0] rx_baud_r;
   logic [3:0]  rx_bit_r;
   logic [7:0]  rx_shift_r;
   logic [7:0]  rx_data_r;
   logic        rx_rdy_r;
   logic        rx_stop_s;

   // Transmit shifter: frame is {stop, data, start}, shifted out LSB first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_shift_r <= 10'h3FF;
         tx_baud_r  <= 16'd0;
         tx_bit_r   <= 4'd0;
         tx_busy_r  <= 1'b0;
         tx_done_r  <= 1'b0;
      end else if (trmt && !tx_busy_r) begin
         tx_shift_r <= {1'b1, tx_data, 1'b0};
         tx_baud_r  <= 16'd0;
         tx_bit_r   <= 4'd0;
         tx_busy_r  <= 1'b1;
         tx_done_r  <= 1'b0;
      end else if (tx_busy_r) begin
         if (tx_baud_r == BAUD_LAST) begin
            tx_baud_r  <= 16'd0;
            tx_shift_r <= {1'b1, tx_shift_r[9:1]};
            if (tx_bit_r == 4'd9) begin
               tx_busy_r <= 1'b0;
               tx_done_r <= 1'b1;
               tx_bit_r  <= 4'd0;
            end else begin
               tx_bit_r <= tx_bit_r + 4'd1;
            end
         end else begin
            tx_baud_r <= tx_baud_r + 16'd1;
         end
      end
   end

   // Two-flop synchronizer on the asynchronous RX pin; idles high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta_r <= 1'b1;
         rx_sync_r <= 1'b1;
      end else begin
         rx_meta_r <= RX;
         rx_sync_r <= rx_meta_r;
      end
   end

   // Stop bit is being sampled this cycle: the byte is complete.
   assign rx_stop_s = rx_busy_r && (rx_baud_r == 16'd0) && (rx_bit_r == 4'd9);

   // Receive sequencer: detect start edge, then sample each bit at mid-bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_busy_r  <= 1'b0;
         rx_baud_r  <= 16'd0;
         rx_bit_r   <= 4'd0;
         rx_shift_r <= 8'h00;
         rx_data_r  <= 8'h00;
      end else if (!rx_busy_r) begin
         if (!rx_sync_r) begin
            rx_busy_r <= 1'b1;
            rx_baud_r <= BAUD_HALF;
            rx_bit_r  <= 4'd0;
         end
      end else if (rx_baud_r != 16'd0) begin
         rx_baud_r <= rx_baud_r - 16'd1;
      end else begin
         rx_baud_r <= BAUD_LAST;
         if ((rx_bit_r == 4'd0) && rx_sync_r) begin
            rx_busy_r <= 1'b0;
         end else if (rx_bit_r == 4'd9) begin
            rx_busy_r <= 1'b0;
            rx_data_r <= rx_shift_r;
         end else begin
            rx_shift_r <= {rx_sync_r, rx_shift_r[7:1]};
            rx_bit_r   <= rx_bit_r + 4'd1;
         end
      end
   end

   // rx_rdy is held from stop-bit sample until the consumer clears it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_rdy_r <= 1'b0;
      end else if (rx_stop_s) begin
         rx_rdy_r <= 1'b1;
      end else if (clr_rx_rdy) begin
         rx_rdy_r <= 1'b0;
      end
   end

   assign TX      = tx_shift_r[0];
   assign tx_done = tx_done_r;
   assign rx_data = rx_data_r;
   assign rx_rdy  = rx_rdy_r;

endmodule

// File: rtl/uart_cmd_wrapper.sv
// Knight-side end of the remote command link.
// Two received bytes (high then low) are assembled into a 16-bit cmd with a
// cmd_rdy flag; the response byte resp is sent back over the same UART.
// Optional build macro CMD_TIMEOUT_EN: abandon a half-received command if the
// low byte does not arrive within TIMEOUT_CYCLES clocks of entering LOW.
module uart_cmd_wrapper
   import uart_cmd_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
   parameter int BAUD_DIV       = DEFAULT_BAUD_DIV
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        RX,
   output logic        TX,
   input  logic [7:0]  resp,
   input  logic        trmt,
   output logic        tx_done,
   output logic [15:0] cmd,
   output logic        cmd_rdy,
   input  logic        clr_cmd_rdy
);

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("uart_cmd_wrapper: TIMEOUT_CYCLES must be at least 1");
   end

   logic [7:0]  rx_data_s;
   logic        rx_rdy_s;
   logic        clr_rx_rdy_s;
   logic        capture_high_s;
   logic        complete_s;

   state_t      state_r;
   logic [7:0]  high_byte_r;
   logic [15:0] cmd_r;
   logic        cmd_rdy_r;

   uart #(
      .BAUD_DIV (BAUD_DIV)
   ) u_uart (
      .clk        (clk),
      .rst_n      (rst_n),
      .RX         (RX),
      .TX         (TX),
      .tx_data    (resp),
      .trmt       (trmt),
      .tx_done    (tx_done),
      .rx_data    (rx_data_s),
      .rx_rdy     (rx_rdy_s),
      .clr_rx_rdy (clr_rx_rdy_s)
   );

   // Decode which byte the current rx_rdy belongs to. rx_rdy is consumed in
   // the same cycle it is seen, so the UART flag is gone before the FSM could
   // look at it a second time.
   always_comb begin
      capture_high_s = 1'b0;
      complete_s     = 1'b0;
      case (state_r)
         HIGH:    capture_high_s = rx_rdy_s;
         LOW:     complete_s     = rx_rdy_s;
         default: begin
            capture_high_s = 1'b0;
            complete_s     = 1'b0;
         end
      endcase
      clr_rx_rdy_s = capture_high_s | complete_s;
   end

`ifdef CMD_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);

   logic [TO_W-1:0] to_cnt_r;
   logic            timeout_s;

   assign timeout_s = (state_r == LOW) && (to_cnt_r == TO_LIMIT);

   // Clocks spent in LOW; held at zero in HIGH so every LOW visit starts fresh.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         to_cnt_r <= {TO_W{1'b0}};
      end else if (state_r != LOW) begin
         to_cnt_r <= {TO_W{1'b0}};
      end else if (!timeout_s) begin
         to_cnt_r <= to_cnt_r + TO_W'(1);
      end
   end
`endif

   // Byte-assembly FSM; cmd only changes when a full pair has arrived.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= HIGH;
         high_byte_r <= 8'h00;
         cmd_r       <= 16'h0000;
      end else begin
         case (state_r)
            HIGH: begin
               if (rx_rdy_s) begin
                  high_byte_r <= rx_data_s;
                  state_r     <= LOW;
               end
            end
            LOW: begin
               if (rx_rdy_s) begin
                  cmd_r   <= pack_cmd(high_byte_r, rx_data_s);
                  state_r <= HIGH;
`ifdef CMD_TIMEOUT_EN
               end else if (timeout_s) begin
                  // Stale high byte is dropped; cmd/cmd_rdy keep the last pair.
                  high_byte_r <= 8'h00;
                  state_r     <= HIGH;
`endif
               end
            end
            default: begin
               state_r <= HIGH;
            end
         endcase
      end
   end

   // cmd_rdy: completing a pair outranks any clear in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd_rdy_r <= 1'b0;
      end else if (complete_s) begin
         cmd_rdy_r <= 1'b1;
      end else if (clr_cmd_rdy || capture_high_s) begin
         cmd_rdy_r <= 1'b0;
      end
   end

   assign cmd     = cmd_r;
   assign cmd_rdy = cmd_rdy_r;

endmodule

// File: tb/tb_uart_cmd_wrapper.sv
// Scoreboard bench for uart_cmd_wrapper: expected commands and transmit bytes
// are queued as stimulus is driven and compared when the DUT produces them.
module tb_uart_cmd_wrapper;
   import uart_cmd_pkg::*;

   localparam int BAUD   = 32;
   localparam int TO_CYC = 5000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        RX = 1'b1;
   logic        trmt = 1'b0;
   logic        clr_cmd_rdy = 1'b0;
   logic [7:0]  resp = 8'h00;
   logic        TX;
   logic        tx_done;
   logic [15:0] cmd;
   logic        cmd_rdy;

   int n_compared = 0;
   int n_mismatched = 0;

   logic [15:0] cmd_q[$];
   logic [7:0]  tx_q[$];

   always #5 clk = ~clk;

   uart_cmd_wrapper #(
      .TIMEOUT_CYCLES (TO_CYC),
      .BAUD_DIV       (BAUD)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .RX          (RX),
      .TX          (TX),
      .resp        (resp),
      .trmt        (trmt),
      .tx_done     (tx_done),
      .cmd         (cmd),
      .cmd_rdy     (cmd_rdy),
      .clr_cmd_rdy (clr_cmd_rdy)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_compared++;
      if (obs !== exp) begin
         n_mismatched++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Drive one 8N1 frame on RX, LSB first, BAUD clocks per bit.
   task automatic send_byte(input logic [7:0] b);
      logic [9:0] frame;
      frame = {1'b1, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         RX = frame[i];
         repeat (BAUD - 1) @(negedge clk);
      end
   endtask

   task automatic wait_rdy(input string tag, input int budget);
      int n;
      n = 0;
      while (!cmd_rdy && n < budget) begin
         @(negedge clk);
         n++;
      end
      check_eq(tag, 32'(cmd_rdy), 32'd1);
   endtask

   // Command monitor: on each rising cmd_rdy pop the scoreboard, check the
   // one-cycle latency from the low-byte rx_rdy, and flag cmd changing alone.
   logic        prev_rdy = 1'b0;
   logic        prev_done = 1'b0;
   logic [15:0] prev_cmd = 16'h0000;
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_rdy  = 1'b0;
         prev_done = 1'b0;
         prev_cmd  = cmd;
      end else begin
         if (cmd_rdy && !prev_rdy) begin
            check_eq("cmd_latency", 32'(prev_done), 32'd1);
            if (cmd_q.size() == 0)
               check_eq("cmd_spurious", 32'(cmd_q.size()), 32'd1);
            else
               check_eq("cmd_value", 32'(cmd), 32'(cmd_q.pop_front()));
         end else if (cmd !== prev_cmd) begin
            check_eq("cmd_stable", 32'(cmd), 32'(prev_cmd));
         end
         prev_rdy  = cmd_rdy;
         prev_cmd  = cmd;
         prev_done = dut.rx_rdy_s && (dut.state_r == LOW);
      end
   end

   // UART receiver model on TX: decode each frame and compare with queue.
   initial begin : tx_model
      logic [7:0] b;
      forever begin
         @(negedge TX);
         repeat (BAUD / 2) @(negedge clk);
         check_eq("tx_start_bit", 32'(TX), 32'd0);
         for (int i = 0; i < 8; i++) begin
            repeat (BAUD) @(negedge clk);
            b[i] = TX;
         end
         repeat (BAUD) @(negedge clk);
         check_eq("tx_stop_bit", 32'(TX), 32'd1);
         if (tx_q.size() == 0)
            check_eq("tx_spurious", 32'(tx_q.size()), 32'd1);
         else
            check_eq("tx_byte", 32'(b), 32'(tx_q.pop_front()));
      end
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int n;
      // Reset state
      repeat (3) @(negedge clk);
      check_eq("reset_cmd", 32'(cmd), 32'h0000);
      check_eq("reset_cmd_rdy", 32'(cmd_rdy), 32'd0);
      check_eq("reset_tx_idle", 32'(TX), 32'd1);
      check_eq("reset_tx_done", 32'(tx_done), 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Basic pair A5,3C
      send_byte(8'hA5);
      repeat (4) @(negedge clk);
      check_eq("rdy_before_low", 32'(cmd_rdy), 32'd0);
      cmd_q.push_back(16'hA53C);
      send_byte(8'h3C);
      wait_rdy("rdy_A53C", 4 * BAUD);
      check_eq("cmd_A53C", 32'(cmd), 32'hA53C);

      // Slow consumer: new high byte clears cmd_rdy, cmd holds old value
      send_byte(8'h12);
      repeat (4) @(negedge clk);
      check_eq("rdy_dropped_on_high", 32'(cmd_rdy), 32'd0);
      check_eq("cmd_held_mid_pair", 32'(cmd), 32'hA53C);
      cmd_q.push_back(16'h1234);
      send_byte(8'h34);
      wait_rdy("rdy_1234", 4 * BAUD);
      check_eq("cmd_1234", 32'(cmd), 32'h1234);

      // Consumer acknowledge
      @(negedge clk);
      clr_cmd_rdy = 1'b1;
      @(negedge clk);
      clr_cmd_rdy = 1'b0;
      check_eq("rdy_cleared", 32'(cmd_rdy), 32'd0);
      check_eq("cmd_after_clr", 32'(cmd), 32'h1234);

      // Acknowledge landing on the completion cycle: set wins
      send_byte(8'h9A);
      cmd_q.push_back(16'h9ABC);
      fork
         send_byte(8'hBC);
         begin
            n = 0;
            while (!(dut.rx_rdy_s && dut.state_r == LOW) && n < 20 * BAUD) begin
               @(negedge clk);
               n++;
            end
            check_eq("coincide_seen", 32'(n < 20 * BAUD), 32'd1);
            clr_cmd_rdy = 1'b1;
            @(negedge clk);
            clr_cmd_rdy = 1'b0;
            check_eq("rdy_set_beats_clr", 32'(cmd_rdy), 32'd1);
         end
      join
      check_eq("cmd_9ABC", 32'(cmd), 32'h9ABC);

      // Transmit A5 while a command arrives on RX
      resp = 8'hA5;
      tx_q.push_back(8'hA5);
      @(negedge clk);
      trmt = 1'b1;
      @(negedge clk);
      trmt = 1'b0;
      resp = 8'h00;
      check_eq("tx_done_while_busy", 32'(tx_done), 32'd0);
      cmd_q.push_back(16'hC37E);
      send_byte(8'hC3);
      send_byte(8'h7E);
      wait_rdy("rdy_C37E", 4 * BAUD);
      check_eq("cmd_C37E", 32'(cmd), 32'hC37E);
      n = 0;
      while (!tx_done && n < 12 * BAUD) begin
         @(negedge clk);
         n++;
      end
      check_eq("tx_done_set", 32'(tx_done), 32'd1);
      check_eq("tx_queue_drained", 32'(tx_q.size()), 32'd0);

      // Reset after the high byte only: stale byte must not pair
      send_byte(8'h11);
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check_eq("midpair_reset_cmd", 32'(cmd), 32'h0000);
      check_eq("midpair_reset_rdy", 32'(cmd_rdy), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      cmd_q.push_back(16'h5678);
      send_byte(8'h56);
      send_byte(8'h78);
      wait_rdy("rdy_5678", 4 * BAUD);
      check_eq("cmd_5678", 32'(cmd), 32'h5678);

      // Long gap after a high byte
      send_byte(8'hFF);
      repeat (TO_CYC + 200) @(negedge clk);
      check_eq("cmd_untouched_gap", 32'(cmd), 32'h5678);
      check_eq("rdy_after_gap_high", 32'(cmd_rdy), 32'd0);
`ifdef CMD_TIMEOUT_EN
      cmd_q.push_back(16'h0102);
      send_byte(8'h01);
      repeat (4) @(negedge clk);
      check_eq("no_stale_pair", 32'(cmd_rdy), 32'd0);
      send_byte(8'h02);
      wait_rdy("rdy_0102", 4 * BAUD);
      check_eq("cmd_0102", 32'(cmd), 32'h0102);
`else
      cmd_q.push_back(16'hFF01);
      send_byte(8'h01);
      wait_rdy("rdy_FF01", 4 * BAUD);
      check_eq("cmd_FF01", 32'(cmd), 32'hFF01);
      send_byte(8'h02);
      repeat (4) @(negedge clk);
      check_eq("rdy_after_02_high", 32'(cmd_rdy), 32'd0);
      check_eq("cmd_FF01_held", 32'(cmd), 32'hFF01);
`endif
      repeat (4) @(negedge clk);
      check_eq("scoreboard_empty", 32'(cmd_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
